prog_loader: RTL

- Writer side of the processor's instruction memory.
- Receives a framed program over the Tiny Tapeout pins (byte on ui_in, strobe on a uio pin) and writes it into instruction memory through a single write port.
- Holds the processor core (PC, pipeline control) in reset while loading, so execution restarts at PC=0 once a load completes.
- Frame format: length byte, then N instruction bytes, then an XOR checksum byte.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Host-pin and instruction-memory signals of the program loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              load_en;
  logic              strobe;
  logic [7:0]        din;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   byte_cnt;

  // Host side: drives the pins, observes memory port and status.
  modport master (
    output load_en, strobe, din,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, byte_cnt
  );

  // Loader side.
  modport slave (
    input  load_en, strobe, din,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, byte_cnt
  );
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory writer: receives a framed program (length, data, XOR
// checksum) over a strobed byte pin and holds the core in reset meanwhile.
module prog_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  prog_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]  len_q;
  logic [7:0]        chk_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              cpu_hold_q;
  logic              load_done_q;
  logic              load_err_q;
  logic [CNT_W-1:0]  byte_cnt_q;

  logic              strobe_edge_c;
  logic [CNT_W-1:0]  byte_cnt_d;
  logic              len_ok_c;

  // Rising edge of the synchronised strobe, plus helpers for the FSM.
  always_comb begin
    strobe_edge_c = s2_q & ~s3_q;
    byte_cnt_d    = byte_cnt_q + CNT_W'(1);
    len_ok_c      = (bus.din != 8'd0) && (bus.din <= 8'(DEPTH));
  end

  // Strobe synchroniser, frame FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      len_q       <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      s1_q     <= bus.strobe;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cpu_hold_q <= 1'b0;
          if (bus.load_en) begin
            state_q     <= S_LEN;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            byte_cnt_q  <= '0;
            chk_q       <= '0;
          end
        end
        S_LEN, S_DATA, S_CHK: begin
          // Dropping load_en aborts and takes priority over any strobe edge.
          if (!bus.load_en) begin
            state_q    <= S_IDLE;
            cpu_hold_q <= 1'b0;
            load_err_q <= 1'b1;
          end else if (strobe_edge_c) begin
            if (state_q == S_LEN) begin
              if (len_ok_c) begin
                len_q   <= bus.din[CNT_W-1:0];
                chk_q   <= bus.din;
                state_q <= S_DATA;
              end else begin
                state_q    <= S_ERR;
                load_err_q <= 1'b1;
              end
            end else if (state_q == S_DATA) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= byte_cnt_q[ADDR_W-1:0];
              mem_wdata_q <= bus.din;
              chk_q       <= chk_q ^ bus.din;
              byte_cnt_q  <= byte_cnt_d;
              if (byte_cnt_d == len_q) begin
                state_q <= S_CHK;
              end
            end else begin
              if (bus.din == chk_q) begin
                state_q     <= S_DONE;
                load_done_q <= 1'b1;
              end else begin
                state_q    <= S_ERR;
                load_err_q <= 1'b1;
              end
            end
          end
        end
        S_DONE, S_ERR: begin
          if (!bus.load_en) begin
            state_q    <= S_IDLE;
            cpu_hold_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;
  assign bus.byte_cnt  = byte_cnt_q;

endmodule
